otp_crypt_scheduler: RTL and testbench
======================================

# otp_crypt_scheduler

Clocked front-end that shares one `otp_encryption_decryption` engine between `NUM_REQ` requesters. It round-robin arbitrates requests and sequences the engine's start/done handshake, including the start release the engine needs before it accepts the next transaction. It returns each result on a shared, ID-tagged response bus and detects a stalled engine with a timeout. It sits between the channel logic and the engine; the engine's `passthrough` is tied 0 at integration, and bypass is served inside this block.

## Interface
Parameters:
- `DATA_W`, 16, request/response/engine data width
- `NUM_REQ`, 2, number of requesters (≥2)
- `ID_W`, `$clog2(NUM_REQ)`, width of `rsp_id`
- `TIMEOUT_CYC`, 15, max cycles spent in ISSUE+BUSY before abort

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  request pending per requester; held until granted
- `req_bypass`  in  NUM_REQ  1 = return data unencrypted, engine untouched
- `req_data`  in  NUM_REQ*DATA_W  packed; requester i at `[i*DATA_W +: DATA_W]`
- `req_ready`  out  NUM_REQ  one-hot grant; data accepted on the edge it is high
- `rsp_valid`  out  1  one-cycle result pulse
- `rsp_id`  out  ID_W  requester index of the result
- `rsp_data`  out  DATA_W  result (engine output, bypass data, or 0 on error)
- `rsp_err`  out  1  qualifies `rsp_valid`: engine timeout
- `eng_start`  out  1  to engine `start`
- `eng_data`  out  DATA_W  to engine `input_data`; holds the latched request
- `eng_done`  in  1  from engine `done` (idle-high)
- `eng_result`  in  DATA_W  from engine `output_data`

## Operation
- FSM states: IDLE, ISSUE, BUSY, RELEASE, RESP.
- IDLE: `req_ready` is combinational, one-hot winner of round-robin among `req_valid`. Priority starts at `last_grant+1` and wraps. On grant, latch data, bypass, and id, then update `last_grant`.
  - Bypass → RESP with `rsp_data` = latched data.
  - Non-bypass → ISSUE.
  - No valid → stay in IDLE.
- ISSUE: `eng_start`=1. When `eng_done`=0 (engine accepted), go to BUSY.
- BUSY: `eng_start`=1. When `eng_done`=1, capture `eng_result`, then go to RELEASE.
- RELEASE: `eng_start`=0 for exactly one cycle, which unlocks the engine. Then go to RESP.
- RESP: `rsp_valid`=1 for one cycle with id, data, and err. Then go to IDLE. No grant is issued in RESP.
- Timeout: a counter clears on entry to ISSUE and increments in ISSUE and BUSY. When it equals `TIMEOUT_CYC`, go to RELEASE with `rsp_err`=1 and `rsp_data`=0.
- `eng_data` updates only on grant. It is stable through ISSUE, BUSY, and RELEASE.
- `req_ready` is never asserted outside IDLE. Requests raised during a transaction wait, with no loss.
- A requester dropping `req_valid` before grant simply withdraws its request. This is legal.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `eng_start`=0, `eng_data`=0, state=IDLE, `last_grant`=NUM_REQ-1 (requester 0 wins first), counter=0.
- Bypass latency: grant edge → `rsp_valid` high the next cycle (2 cycles from valid to response).
- Engine path: grant (cycle 0), then ISSUE ≥1 cycle, BUSY ≥1 cycle, RELEASE 1 cycle, RESP 1 cycle. Minimum 5 cycles from grant to the end of the response.
- Back-to-back: the next grant can occur in the cycle after RESP. With all requesters valid, grants rotate 0,1,…,NUM_REQ-1,0.
- `eng_done`=1 already observed in ISSUE (engine missed the start) counts toward the timeout; there is no spurious completion.
- `reset_n` low mid-transaction: all outputs go to reset values immediately (`eng_start` drops asynchronously). In-flight results are discarded and no response is issued.
- The timeout and `eng_done` rising in the same cycle as the counter limit resolve as success; completion wins.

## Structure
- Package `otp_sched_pkg`: state enum `otp_sched_state_t`, default `DATA_W`/`TIMEOUT_CYC` constants, timeout counter width `$clog2(TIMEOUT_CYC+1)`.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `req`, `last_grant`.
  - Outputs: one-hot `grant`, encoded `grant_idx`.
  - Purely combinational.
- Top: FSM, latches, timeout counter, response registers.

## Test plan
- Reset release, req0 valid, data 16'h1234, engine model with key 16'h3327 → `rsp_valid` with id 0, data 16'h2113, err 0, ≥5 cycles after grant; one `eng_start` pulse train with a 1-cycle low in RELEASE.
- req1 bypass, data 16'hABCD → response 2 cycles after valid with id 1, data 16'hABCD; `eng_start` stays 0.
- req0 and req1 both held valid for 4 transactions → grant order 0,1,0,1; the requester not granted is never lost.
- Engine model holds `eng_done`=1 (never accepts) → after 15 cycles, RELEASE then `rsp_err`=1 with data 16'h0000; the next request completes normally.
- `reset_n` pulsed low during BUSY → `eng_start` and `rsp_valid` go 0 immediately; after release, requester 0 has priority and no stale response appears.
- `eng_done` rises on the exact timeout cycle → response has err 0 and carries the engine result.

Source files
------------

// File: rtl/otp_crypt_scheduler_pkg.sv
// Shared types and defaults for the OTP engine scheduler.
package otp_sched_pkg;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RELEASE,
    S_RESP
  } otp_sched_state_t;

  // Width of a counter that must be able to hold the value cyc.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/otp_crypt_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the requester after last_grant has
// highest priority, wrapping around.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int unsigned best_dist;

  // Pick the valid requester with the smallest distance past last_grant.
  always_comb begin
    grant_idx = '0;
    best_dist = N;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && (((i + N - 1 - 32'(last_grant)) % N) < best_dist)) begin
        best_dist = (i + N - 1 - 32'(last_grant)) % N;
        grant_idx = IW'(i);
      end
    end
    grant = '0;
    if (best_dist < N) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/otp_crypt_scheduler.sv
// Shares one OTP engine between NUM_REQ requesters: round-robin grant,
// engine start/done sequencing with start release, bypass, and timeout.
module otp_crypt_scheduler
  import otp_sched_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ID_W        = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_bypass,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_data,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_result
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);

  otp_sched_state_t    state_q, state_d;
  logic [ID_W-1:0]     last_grant_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   eng_data_q;
  logic [DATA_W-1:0]   res_data_q;
  logic                res_err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [DATA_W-1:0]   sel_data;
  logic                timeout;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign sel_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];
  // cnt_q holds cycles already spent in ISSUE+BUSY; this is the last allowed one.
  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign eng_data = eng_data_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; in BUSY, completion takes precedence over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (|grant) state_d = req_bypass[grant_idx] ? S_RESP : S_ISSUE;
      S_ISSUE: begin
        if (timeout)        state_d = S_RELEASE;
        else if (!eng_done) state_d = S_BUSY;
      end
      S_BUSY:    if (eng_done || timeout) state_d = S_RELEASE;
      S_RELEASE: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode; responses are driven only during RESP.
  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    unique case (state_q)
      S_IDLE:         if (reset_n) req_ready = grant;
      S_ISSUE, S_BUSY: eng_start = 1'b1;
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = res_data_q;
        rsp_err   = res_err_q;
      end
      default: ;
    endcase
  end

  // Grant latches, timeout counter and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      eng_data_q   <= '0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|grant) begin
            last_grant_q <= grant_idx;
            id_q         <= grant_idx;
            eng_data_q   <= sel_data;
            res_data_q   <= sel_data;
            res_err_q    <= 1'b0;
            cnt_q        <= '0;
          end
        end
        S_ISSUE, S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (state_q == S_BUSY && eng_done) begin
            res_data_q <= eng_result;
            res_err_q  <= 1'b0;
          end else if (timeout) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_crypt_scheduler.sv
// Self-checking bench for otp_crypt_scheduler with an XOR-key engine model.
module tb_otp_crypt_scheduler;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned TO = 15;
  localparam logic [DW-1:0] KEY = 16'h3327;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_bypass;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               eng_start;
  logic [DW-1:0]      eng_data;
  logic               eng_done;
  logic [DW-1:0]      eng_result;

  always #5 clk = ~clk;

  otp_crypt_scheduler #(
    .DATA_W      (DW),
    .NUM_REQ     (NR),
    .ID_W        (IW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_bypass (req_bypass),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Engine model: idle-high done, accepts on start, result = data ^ KEY after
  // lat cycles, then needs start low before the next acceptance.
  bit stuck;
  int lat;
  int e_cnt;
  bit e_run, e_lock;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_done   <= 1'b1;
      eng_result <= '0;
      e_run      <= 1'b0;
      e_lock     <= 1'b0;
      e_cnt      <= 0;
    end else if (!stuck) begin
      if (e_run) begin
        if (e_cnt <= 1) begin
          eng_done   <= 1'b1;
          eng_result <= eng_data ^ KEY;
          e_run      <= 1'b0;
          e_lock     <= 1'b1;
        end else e_cnt <= e_cnt - 1;
      end else if (!eng_start) e_lock <= 1'b0;
      else if (!e_lock) begin
        eng_done <= 1'b0;
        e_run    <= 1'b1;
        e_cnt    <= lat;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-transaction bookkeeping by cycle number.
  int            m_last;
  bit            m_busy, m_txn, m_acc;
  int            m_spent, m_resp_cyc;
  logic [DW-1:0] m_eng_data, m_rsp_data;
  int            m_rsp_id;
  bit            m_rsp_err;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last <= NR - 1; m_busy <= 0; m_txn <= 0; m_acc <= 0; m_spent <= 0;
      m_resp_cyc <= -1; m_eng_data <= '0; m_rsp_data <= '0; m_rsp_id <= 0; m_rsp_err <= 0;
    end else if (!m_busy) begin
      if (rr_pick(req_valid, m_last) >= 0) begin
        m_last     <= rr_pick(req_valid, m_last);
        m_rsp_id   <= rr_pick(req_valid, m_last);
        m_eng_data <= req_data[rr_pick(req_valid, m_last)*DW +: DW];
        m_busy     <= 1;
        if (req_bypass[rr_pick(req_valid, m_last)]) begin
          m_rsp_data <= req_data[rr_pick(req_valid, m_last)*DW +: DW];
          m_rsp_err  <= 0;
          m_resp_cyc <= cyc + 1;
        end else begin
          m_txn <= 1; m_spent <= 0; m_acc <= 0;
        end
      end
    end else if (m_txn) begin
      if (m_acc && eng_done) begin
        m_txn <= 0; m_rsp_data <= eng_result; m_rsp_err <= 0; m_resp_cyc <= cyc + 2;
      end else if (m_spent + 1 == TO) begin
        m_txn <= 0; m_rsp_data <= '0; m_rsp_err <= 1; m_resp_cyc <= cyc + 2;
      end else begin
        m_spent <= m_spent + 1;
        if (!eng_done) m_acc <= 1;
      end
    end else if (cyc == m_resp_cyc) m_busy <= 0;
  end

  typedef struct {int cyc; int id; logic [DW-1:0] data; logic err;} rsp_t;
  rsp_t rlog[$];
  int   gidx[$];
  int   gcyc[$];

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r;
    r = '0;
    if (!m_busy && rr_pick(req_valid, m_last) >= 0) r[rr_pick(req_valid, m_last)] = 1'b1;
    return r;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_data",  eng_data, 0);
    end else begin
      chk("req_ready", req_ready, exp_ready());
      chk("eng_start", eng_start, m_txn);
      chk("eng_data",  eng_data, m_eng_data);
      chk("rsp_valid", rsp_valid, cyc == m_resp_cyc);
      if (cyc == m_resp_cyc) begin
        chk("rsp_id",   rsp_id, m_rsp_id);
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("rsp_err",  rsp_err, m_rsp_err);
      end
      if (rsp_valid) rlog.push_back('{cyc, int'(rsp_id), rsp_data, rsp_err});
      if (req_ready != '0) begin
        gidx.push_back(oh_idx(req_ready));
        gcyc.push_back(cyc);
      end
    end
  end

  task automatic do_req(input int i, input bit byp, input logic [DW-1:0] d, output int t_raise);
    bit got;
    got = 0;
    @(posedge clk); #2;
    req_valid[i] = 1'b1; req_bypass[i] = byp; req_data[i*DW +: DW] = d;
    t_raise = cyc;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    chk("grant_wait", got, 1);
    @(posedge clk); #2;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (!m_busy) ok = 1;
    end
    chk("idle_wait", ok, 1);
  endtask

  task automatic chk_rsp(input string nm, input int back, input int id,
                         input logic [DW-1:0] d, input bit err);
    if (rlog.size() < back) chk({nm, "_present"}, rlog.size(), back);
    else begin
      chk({nm, "_id"},   rlog[rlog.size()-back].id, id);
      chk({nm, "_data"}, rlog[rlog.size()-back].data, d);
      chk({nm, "_err"},  rlog[rlog.size()-back].err, err);
    end
  endtask

  task automatic chk_lat(input string nm, input int exp);
    if (rlog.size() == 0 || gcyc.size() == 0) chk({nm, "_present"}, 0, 1);
    else chk(nm, rlog[$].cyc - gcyc[$], exp);
  endtask

  int t0, nrsp, base, c;

  initial begin
    req_valid = '0; req_bypass = '0; req_data = '0;
    stuck = 0; lat = 1; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Engine transaction from requester 0.
    do_req(0, 0, 16'h1234, t0);
    wait_idle();
    chk_rsp("t1", 1, 0, 16'h2113, 0);
    chk_lat("t1_latency", 5);

    // Bypass from requester 1.
    do_req(1, 1, 16'hABCD, t0);
    wait_idle();
    chk_rsp("t2", 1, 1, 16'hABCD, 0);
    chk("t2_grant_cycle", gcyc[$], t0);
    chk("t2_rsp_cycle", rlog[$].cyc, t0 + 1);

    // Both requesters held valid for four grants.
    base = gidx.size();
    @(posedge clk); #2;
    req_valid = 2'b11; req_bypass = 2'b10; req_data = {16'h00FF, 16'h5555};
    for (c = 0; c < 200 && gidx.size() < base + 4; c++) @(negedge clk);
    chk("t3_grants_seen", gidx.size() >= base + 4, 1);
    @(posedge clk); #2;
    req_valid = '0; req_bypass = '0;
    wait_idle();
    if (gidx.size() >= base + 4) begin
      chk("t3_g0", gidx[base], 0);
      chk("t3_g1", gidx[base+1], 1);
      chk("t3_g2", gidx[base+2], 0);
      chk("t3_g3", gidx[base+3], 1);
    end
    chk_rsp("t3_r0", 4, 0, 16'h6672, 0);
    chk_rsp("t3_r1", 3, 1, 16'h00FF, 0);
    chk_rsp("t3_r2", 2, 0, 16'h6672, 0);
    chk_rsp("t3_r3", 1, 1, 16'h00FF, 0);

    // Engine never accepts: timeout error, then a normal transaction.
    stuck = 1;
    do_req(0, 0, 16'hBEEF, t0);
    wait_idle();
    chk_rsp("t4", 1, 0, 16'h0000, 1);
    chk_lat("t4_latency", 17);
    stuck = 0;
    do_req(1, 0, 16'h1234, t0);
    wait_idle();
    chk_rsp("t4b", 1, 1, 16'h2113, 0);
    chk_lat("t4b_latency", 5);

    // Done arrives on the last allowed cycle: success wins.
    lat = 13;
    do_req(0, 0, 16'h0F0F, t0);
    wait_idle();
    chk_rsp("t6", 1, 0, 16'h3C28, 0);
    chk_lat("t6_latency", 17);
    lat = 1;

    // Reset during BUSY.
    lat = 6;
    nrsp = rlog.size();
    do_req(1, 0, 16'hAAAA, t0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_eng_start_async", eng_start, 0);
    chk("t5_rsp_valid_async", rsp_valid, 0);
    chk("t5_eng_data_async", eng_data, 0);
    lat = 1;
    req_valid = 2'b11; req_bypass = 2'b11; req_data = {16'h2222, 16'h1111};
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    base = gidx.size();
    for (c = 0; c < 50 && gidx.size() < base + 1; c++) @(negedge clk);
    @(posedge clk); #2 req_valid[0] = 1'b0;
    for (c = 0; c < 50 && gidx.size() < base + 2; c++) @(negedge clk);
    @(posedge clk); #2 req_valid[1] = 1'b0;
    wait_idle();
    chk("t5_rsp_count", rlog.size(), nrsp + 2);
    if (gidx.size() >= base + 2) begin
      chk("t5_first_grant", gidx[base], 0);
      chk("t5_second_grant", gidx[base+1], 1);
    end else chk("t5_grants_seen", gidx.size(), base + 2);
    chk_rsp("t5_r0", 2, 0, 16'h1111, 0);
    chk_rsp("t5_r1", 1, 1, 16'h2222, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
